// File: rtl/regfile_dump_pkg.sv
// Shared constants and state type for the register-file dump block.
// Also used by the register file model that feeds it.
package regfile_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned NREG    = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned XZR_IDX = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND_LO,
        ST_SEND_HI
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying dumped register words with their index.
// The last flag marks the final register of a dump.
interface regfile_dump_if #(
    parameter int unsigned DATA_W = 64
) ();
    import regfile_pkg::*;

    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_last;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_idx,
        output dout_last,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_idx,
        input  dout_last,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/regfile.sv
// Two-read/one-write register file; index XZR_IDX reads as zero.
// Writes to XZR_IDX are discarded.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(XZR_IDX);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != XZR)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == XZR) ? '0 : regs[ra1];
        rd2 = (ra2 == XZR) ? '0 : regs[ra2];
    end

endmodule

// File: rtl/regfile_dump.sv
// Streams NREG registers out two at a time: one read cycle fetches a pair,
// then the low and high words are sent as separate valid/ready beats.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned NREG   = regfile_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    regfile_dump_if.master    strm
);

    localparam int unsigned K_W = ADDR_W - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NREG / 2 - 1);

    dump_state_t       state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] lo_q, hi_q;
    logic [ADDR_W-1:0] ra1_q, ra2_q;
    logic              done_q;
    logic              last_pair;
    logic              xfer;

    assign last_pair = (k_q == K_LAST);
    assign xfer      = ((state_q == ST_SEND_LO) || (state_q == ST_SEND_HI)) && strm.dout_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start coinciding with the done pulse is dropped, so IDLE waits out done_q.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d = ST_READ;
                    k_d     = '0;
                end
            end
            ST_READ: state_d = ST_SEND_LO;
            ST_SEND_LO: begin
                if (xfer) state_d = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                if (xfer) begin
                    if (last_pair) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READ;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy            = 1'b1;
        strm.dout_valid = 1'b0;
        strm.dout       = '0;
        strm.dout_idx   = '0;
        strm.dout_last  = 1'b0;
        unique case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_READ: ;
            ST_SEND_LO: begin
                strm.dout_valid = 1'b1;
                strm.dout       = lo_q;
                strm.dout_idx   = {k_q, 1'b0};
            end
            ST_SEND_HI: begin
                strm.dout_valid = 1'b1;
                strm.dout       = hi_q;
                strm.dout_idx   = {k_q, 1'b1};
                strm.dout_last  = last_pair;
            end
            default: busy = 1'b0;
        endcase
    end

    // Read addresses are registered on entry to READ and then simply held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q    <= '0;
            ra1_q  <= '0;
            ra2_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            done_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            done_q <= (state_q == ST_SEND_HI) && xfer && last_pair;
            if (state_d == ST_READ) begin
                ra1_q <= {k_d, 1'b0};
                ra2_q <= {k_d, 1'b1};
            end
            if (state_q == ST_READ) begin
                lo_q <= rd1;
                hi_q <= rd2;
            end
        end
    end

    assign ra1  = ra1_q;
    assign ra2  = ra2_q;
    assign done = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump driven from a preloaded regfile; expected beats come
// from an array of the register contents the bench wrote.
module tb_regfile_dump;
    import regfile_pkg::*;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rf_reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [4:0]    ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic          we = 1'b0;
    logic [4:0]    wa = '0;
    logic [DW-1:0] wd = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model [32];

    regfile_dump_if #(.DATA_W(DW)) strm ();

    regfile_dump #(.DATA_W(DW), .NREG(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .strm    (strm.master)
    );

    regfile #(.DATA_W(DW)) rf (
        .clk     (clk),
        .reset_n (rf_reset_n),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input int a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = 5'(a);
        wd = d;
        tick();
        we = 1'b0;
        model[a] = (a == 31) ? '0 : d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_done"},  64'(done), 64'd0);
        check({tag, "_valid"}, 64'(strm.dout_valid), 64'd0);
        check({tag, "_last"},  64'(strm.dout_last), 64'd0);
        check({tag, "_dout"},  strm.dout, 64'd0);
        check({tag, "_idx"},   64'(strm.dout_idx), 64'd0);
        check({tag, "_ra1"},   64'(ra1), 64'd0);
        check({tag, "_ra2"},   64'(ra2), 64'd0);
    endtask

    // Runs one dump; negative stall_at/start_at/abort_at disable that event.
    task automatic run_dump(input int stall_at, input int start_at, input int abort_at,
                            input bit rnd, output int beats, output int cycles,
                            output int dones, output int first_valid);
        int exp_idx, stalled;
        bit go, last_flag, finished;
        beats = 0; cycles = 0; dones = 0; first_valid = -1;
        exp_idx = 0; stalled = 0; finished = 1'b0;
        strm.dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        while (!finished && cycles < 400) begin
            if (strm.dout_valid) begin
                if (first_valid < 0) first_valid = cycles;
                check("beat_idx",  64'(strm.dout_idx), 64'(exp_idx));
                check("beat_data", strm.dout, model[exp_idx]);
                check("beat_last", 64'(strm.dout_last), 64'(exp_idx == 31));
                if (exp_idx == abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    check_all_zero("abort");
                    #1 reset_n = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        check("no_done_after_abort", 64'(done), 64'd0);
                    end
                    return;
                end
            end
            if (strm.dout_valid && exp_idx == stall_at && stalled < 3) begin
                strm.dout_ready = 1'b0;
                stalled++;
            end else begin
                strm.dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = strm.dout_valid && (exp_idx == start_at);
            go = strm.dout_valid && strm.dout_ready;
            last_flag = strm.dout_last;
            tick();
            cycles++;
            start = 1'b0;
            if (go) begin
                exp_idx++;
                beats++;
            end
            if (done) begin
                dones++;
                check("done_after_final", 64'(exp_idx), 64'd32);
                check("last_on_final", 64'(go && last_flag), 64'd1);
                check("busy_low_at_done", 64'(busy), 64'd0);
                start = 1'b1;
                tick();
                start = 1'b0;
                check("start_at_done_ignored", 64'(busy), 64'd0);
                check("done_single_pulse", 64'(done), 64'd0);
                finished = 1'b1;
            end
        end
        if (!finished) check("dump_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int beats, cycles, dones, fv;
        strm.dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;

        #2;
        check_all_zero("reset");
        #6;
        reset_n    = 1'b1;
        rf_reset_n = 1'b1;
        tick();

        rf_write(4, 64'd127);
        rf_write(5, 64'd91241);
        rf_write(31, 64'd52351);

        run_dump(-1, -1, -1, 1'b0, beats, cycles, dones, fv);
        check("plain_beats", 64'(beats), 64'd32);
        check("plain_cycles", 64'(cycles), 64'd48);
        check("plain_dones", 64'(dones), 64'd1);
        check("first_beat_latency", 64'(fv), 64'd1);
        check("ra1_held", 64'(ra1), 64'd30);
        check("ra2_held", 64'(ra2), 64'd31);

        run_dump(5, -1, -1, 1'b0, beats, cycles, dones, fv);
        check("stall_beats", 64'(beats), 64'd32);
        check("stall_cycles", 64'(cycles), 64'd51);
        check("stall_dones", 64'(dones), 64'd1);

        run_dump(-1, 10, -1, 1'b0, beats, cycles, dones, fv);
        check("midstart_beats", 64'(beats), 64'd32);
        check("midstart_cycles", 64'(cycles), 64'd48);
        check("midstart_dones", 64'(dones), 64'd1);

        run_dump(-1, -1, 17, 1'b0, beats, cycles, dones, fv);
        check("abort_beats", 64'(beats), 64'd17);
        check("abort_dones", 64'(dones), 64'd0);

        run_dump(-1, -1, -1, 1'b0, beats, cycles, dones, fv);
        check("restart_beats", 64'(beats), 64'd32);
        check("restart_latency", 64'(fv), 64'd1);
        check("restart_dones", 64'(dones), 64'd1);

        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < 32; a++) rf_write(a, {$urandom, $urandom});
            run_dump(-1, -1, -1, 1'b1, beats, cycles, dones, fv);
            check("rand_beats", 64'(beats), 64'd32);
            check("rand_dones", 64'(dones), 64'd1);
            check("rand_min_cycles", 64'(cycles >= 48), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter DATA_W, default 64: register and stream word width.
REQ-002 Parameter NREG, default 32: number of registers dumped; SHALL be even.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a dump.
REQ-006 busy  output  1  high from the cycle after an accepted start until the final beat is accepted.
REQ-007 done  output  1  one-cycle pulse in the cycle after the final beat is accepted.
REQ-008 ra1  output  5  register file read address, port 1.
REQ-009 ra2  output  5  register file read address, port 2.
REQ-010 rd1  input  DATA_W  combinational read data for ra1.
REQ-011 rd2  input  DATA_W  combinational read data for ra2.
REQ-012 dout  output  DATA_W  stream data word.
REQ-013 dout_idx  output  5  register index of dout.
REQ-014 dout_last  output  1  high on the beat with dout_idx = NREG-1.
REQ-015 dout_valid  output  1  stream valid.
REQ-016 dout_ready  input  1  stream ready; a beat transfers when valid and ready are both high.

Function
REQ-017 States: IDLE, READ, SEND_LO, SEND_HI.
REQ-018 IDLE: start=1 -> READ with pair counter k=0; start is ignored in every other state.
REQ-019 READ (1 cycle): ra1=2k, ra2=2k+1; rd1 and rd2 are captured into lo_q and hi_q at the clock edge; next state is SEND_LO.
REQ-020 Outside READ, ra1 and ra2 SHALL hold their last driven values (0 after reset).
REQ-021 SEND_LO: dout=lo_q, dout_idx=2k, dout_valid=1; on transfer -> SEND_HI.
REQ-022 SEND_HI: dout=hi_q, dout_idx=2k+1, dout_valid=1; on transfer: if k=NREG/2-1, -> IDLE and pulse done; else k+1 and -> READ.
REQ-023 dout_valid SHALL be 0 in IDLE and READ.
REQ-024 While dout_valid=1 and dout_ready=0, dout, dout_idx and dout_last SHALL remain stable.
REQ-025 Latency: start accepted at edge N; busy=1 after edge N; first valid beat (idx 0) after edge N+1.
REQ-026 A dump with dout_ready held at 1 SHALL take 3*NREG/2 cycles from start acceptance to done.
REQ-027 Data passes through unmodified; X31 therefore streams whatever the register file returns (0 for XZR).
REQ-028 start asserted in the same cycle as done SHALL be ignored; a new dump requires start in IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force state=IDLE, k=0, busy=0, done=0, dout_valid=0, dout_last=0, dout=0, dout_idx=0, ra1=0, ra2=0, lo_q=0, hi_q=0.
REQ-030 Reset mid-dump SHALL abort the dump without a done pulse; the next start restarts from idx 0.

Structure
REQ-031 Shared package regfile_pkg SHALL hold DATA_W, NREG, ADDR_W=5, XZR_IDX=31 and the dump state enum.
REQ-032 The block SHALL be a single module with no sub-modules; the bench instantiates it alongside regfile.

Verification
REQ-033 Preload the regfile with X4=127, X5=91241 and X31=52351 (the X31 write is discarded); dump with ready=1 -> idx4=127, idx5=91241, idx31=0, all other registers 0, 32 beats, done after 48 cycles.
REQ-034 Hold dout_ready low for 3 cycles on the idx5 beat -> dout stays at 91241 and idx stays at 5; next beat is idx6.
REQ-035 Assert start during the idx10 beat -> ignored; beat count is exactly 32 and there is a single done pulse.
REQ-036 Assert reset_n low during the idx17 beat -> all outputs 0 immediately and no done pulse; a new start yields idx0 first.
REQ-037 Check dout_last -> high only on idx31, and that beat coincides with the final transfer before done.
